// File: rtl/axi_wr_pkg.sv
// Shared definitions for the AXI4 write burst engine: FSM state codes,
// AXI response constant, 4 KB page size and the burst length helper.
package axi_wr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_AW    = 2'd1;
  localparam state_t S_W     = 2'd2;
  localparam state_t S_BWAIT = 2'd3;

  localparam logic [1:0]  BRESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K = 4096;

  // Length of the next burst in beats: limited by the burst cap, the beats
  // still to be sent and the beats left before the next 4 KB page.
  // addr is the byte offset inside the page; size_log2 is log2(bytes/beat).
  function automatic logic [8:0] burst_len(input logic [11:0]  addr,
                                           input logic [31:0]  remaining,
                                           input logic [8:0]   max_beats,
                                           input int unsigned  size_log2);
    logic [12:0] room;
    logic [8:0]  len;
    room = (13'(BOUNDARY_4K) - {1'b0, addr}) >> size_log2;
    len  = max_beats;
    if (remaining < {23'd0, len}) len = remaining[8:0];
    if (room < {4'd0, len})       len = room[8:0];
    return len;
  endfunction

endpackage

// File: rtl/axi_wr_data_fifo.sv
// Synchronous data prefetch FIFO with fall-through read: dout always shows
// the oldest entry while empty is low. Only pointers/count are reset.
module axi_wr_data_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 512
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [DATA_W-1:0]                din,
  input  logic                             pop,
  output logic [DATA_W-1:0]                dout,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; data words carry no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_burst_engine.sv
// AXI4 write master: streams a buffer from a fixed-latency RAM read port to
// memory as INCR bursts, split at MAX_BURST beats and at 4 KB pages, with up
// to MAX_OUTSTANDING bursts awaiting a write response.
// Optional build macro AXI_WR_PERF_CNT_EN adds o_cyc_cnt / o_stall_cnt.
module axi_wr_burst_engine
  import axi_wr_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH      = 512,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int RD_ADDR_WIDTH       = 12,
  parameter int RD_DELAY            = 3,
  parameter int MAX_BURST           = 64,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  output logic                             o_done,
  output logic                             o_err,
`ifdef AXI_WR_PERF_CNT_EN
  output logic [31:0]                      o_cyc_cnt,
  output logic [31:0]                      o_stall_cnt,
`endif
  input  logic [AXI_ADDR_WIDTH-1:0]        i_data_ptr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0]   i_size_bytes,
  output logic [RD_ADDR_WIDTH-1:0]         o_rdaddr,
  output logic                             o_rden,
  input  logic [AXI_DATA_WIDTH-1:0]        i_rddata,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                             m_axi_wlast,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  input  logic [1:0]                       m_axi_bresp
);

  localparam int          BYTES = AXI_DATA_WIDTH/8;
  localparam int unsigned LOG_B = $clog2(BYTES);
  localparam int          XS    = AXI_XFER_SIZE_WIDTH;
  localparam int          FCW   = $clog2(FIFO_DEPTH+1);
  localparam int          IFW   = FCW + 1;
  localparam int          OCW   = $clog2(MAX_OUTSTANDING+1);

  // Strobe for a partial final beat: the low rem bytes are valid.
  function automatic logic [BYTES-1:0] tail_strb(input logic [LOG_B-1:0] rem);
    logic [BYTES-1:0] m;
    m = '1;
    if (rem != '0) m = m >> (BYTES - int'(rem));
    return m;
  endfunction

  state_t              state;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [XS-1:0]       beats_left;   // beats not yet claimed by an AW
  logic [XS-1:0]       rd_left;      // source words not yet requested
  logic [8:0]          w_len;
  logic [8:0]          w_cnt;
  logic [BYTES-1:0]    last_strb;
  logic [OCW-1:0]      outstanding;
  logic [RD_DELAY-1:0] vld_p;        // read-request valid per RAM latency stage
  logic [IFW-1:0]      inflight;

  logic                start_ok;
  logic [LOG_B-1:0]    size_rem;
  logic [XS-1:0]       size_beats;
  logic [8:0]          burst_cur;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                rd_issue;

  logic [AXI_DATA_WIDTH-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCW-1:0]      fifo_count;

  assign start_ok   = i_start && (state == S_IDLE);
  assign size_rem   = i_size_bytes[LOG_B-1:0];
  assign size_beats = (i_size_bytes >> LOG_B) + XS'(size_rem != '0);
  assign burst_cur  = burst_len(aw_addr[11:0], 32'(beats_left), 9'(MAX_BURST), LOG_B);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;

  assign o_done        = (state == S_IDLE);
  assign m_axi_bready  = 1'b1;
  assign m_axi_awvalid = (state == S_AW) && (outstanding < OCW'(MAX_OUTSTANDING));
  assign m_axi_awaddr  = aw_addr;
  assign m_axi_awlen   = 8'(burst_cur - 9'd1);
  assign m_axi_wvalid  = (state == S_W) && !fifo_empty;
  assign m_axi_wdata   = fifo_dout;
  assign m_axi_wlast   = (w_cnt == w_len - 9'd1);
  assign m_axi_wstrb   = (m_axi_wlast && beats_left == '0) ? last_strb : '1;

  // Count read requests still travelling through the RAM latency.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_DELAY; i++) inflight = inflight + IFW'(vld_p[i]);
  end

  assign rd_issue = (rd_left != '0) && !fifo_full &&
                    ((IFW'(fifo_count) + inflight) < IFW'(FIFO_DEPTH));
  assign o_rden   = rd_issue;

  // Burst FSM, response accounting and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beats_left  <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      outstanding <= '0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_size_bytes == '0) begin
              state <= S_BWAIT;
            end else begin
              state      <= S_AW;
              beats_left <= size_beats;
            end
          end
        end
        S_AW: begin
          if (aw_hs) begin
            state      <= S_W;
            beats_left <= beats_left - XS'(burst_cur);
            w_len      <= burst_cur;
            w_cnt      <= '0;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (m_axi_wlast) begin
              w_cnt <= '0;
              state <= (beats_left != '0) ? S_AW : S_BWAIT;
            end else begin
              w_cnt <= w_cnt + 9'd1;
            end
          end
        end
        S_BWAIT: begin
          if (outstanding == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      case ({aw_hs, b_hs && outstanding != '0})
        2'b10:   outstanding <= outstanding + OCW'(1);
        2'b01:   outstanding <= outstanding - OCW'(1);
        default: outstanding <= outstanding;
      endcase

      if (start_ok) o_err <= 1'b0;
      if (b_hs && m_axi_bresp != BRESP_OKAY) o_err <= 1'b1;
    end
  end

  // Address and final-strobe payload; stable while awvalid waits.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      aw_addr   <= i_data_ptr;
      last_strb <= tail_strb(size_rem);
    end else if (aw_hs) begin
      aw_addr <= aw_addr + (AXI_ADDR_WIDTH'(burst_cur) << LOG_B);
    end
  end

  // Prefetch requests: address counter, remaining words and latency pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdaddr <= '0;
      rd_left  <= '0;
      vld_p    <= '0;
    end else begin
      if (start_ok) begin
        o_rdaddr <= '0;
        rd_left  <= size_beats;
      end else if (rd_issue) begin
        o_rdaddr <= o_rdaddr + RD_ADDR_WIDTH'(1);
        rd_left  <= rd_left - XS'(1);
      end
      vld_p[0] <= rd_issue;
      for (int i = 1; i < RD_DELAY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  axi_wr_data_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (AXI_DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p[RD_DELAY-1]),
    .din   (i_rddata),
    .pop   (w_hs),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef AXI_WR_PERF_CNT_EN
  // Saturating busy-cycle and write-stall counters, cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cyc_cnt   <= '0;
      o_stall_cnt <= '0;
    end else if (start_ok) begin
      o_cyc_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (state != S_IDLE && o_cyc_cnt != '1) o_cyc_cnt <= o_cyc_cnt + 32'd1;
      if (m_axi_wvalid && !m_axi_wready && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Scoreboard bench for axi_wr_burst_engine: a transfer-level model fills
// expected AW/W queues at start; a negedge monitor pops and compares on
// every handshake while a slave model returns B responses.
module tb_axi_wr_burst_engine;

  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int XS  = 32;
  localparam int RAW = 12;
  localparam int RDD = 3;
  localparam int MB  = 64;
  localparam int MO  = 2;
  localparam int FD  = 16;
  localparam int BY  = DW/8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic           i_start = 1'b0;
  logic           o_done, o_err;
  logic [AW-1:0]  i_data_ptr = '0;
  logic [XS-1:0]  i_size_bytes = '0;
  logic [RAW-1:0] o_rdaddr;
  logic           o_rden;
  logic [DW-1:0]  i_rddata;
  logic           m_axi_awvalid, m_axi_awready = 1'b1;
  logic [AW-1:0]  m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic           m_axi_wvalid, m_axi_wready = 1'b1;
  logic [DW-1:0]  m_axi_wdata;
  logic [BY-1:0]  m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_bvalid = 1'b0, m_axi_bready;
  logic [1:0]     m_axi_bresp = 2'b00;

  axi_wr_burst_engine #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_XFER_SIZE_WIDTH(XS),
    .RD_ADDR_WIDTH(RAW), .RD_DELAY(RDD), .MAX_BURST(MB),
    .MAX_OUTSTANDING(MO), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_done(o_done), .o_err(o_err),
    .i_data_ptr(i_data_ptr), .i_size_bytes(i_size_bytes),
    .o_rdaddr(o_rdaddr), .o_rden(o_rden), .i_rddata(i_rddata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [DW-1:0] data; logic [BY-1:0] strb; logic last; } w_t;

  aw_t        aw_q[$];
  w_t         w_q[$];
  logic [1:0] b_q[$];

  int total = 0;
  int bad   = 0;
  int unsigned salt = 0;
  int w_burst_cnt = 0;
  int err_burst   = -1;
  bit b_hold      = 1'b0;
  bit rnd_ready   = 1'b0;
  int aw_hs_cnt   = 0;
  int b_hs_cnt    = 0;
  int w_hs_cnt    = 0;

  // Source word content: a function of word index and a per-transfer salt.
  function automatic logic [DW-1:0] pat(input int unsigned idx, input int unsigned s);
    logic [DW-1:0] v;
    for (int k = 0; k < DW/32; k++)
      v[k*32 +: 32] = (idx * 32'h9E3779B1) ^ (s + k * 32'h01000193);
    return v;
  endfunction

  function automatic logic [BY-1:0] strb_of(input int unsigned nbytes);
    logic [BY-1:0] s;
    s = '0;
    for (int i = 0; i < BY; i++) if (i < nbytes) s[i] = 1'b1;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer-level reference: plain arithmetic over the byte range.
  task automatic model(input logic [AW-1:0] ptr, input int unsigned size);
    longint unsigned a;
    int unsigned beats, rem, room, len, left, idx;
    w_t w;
    beats = (size + BY - 1) / BY;
    rem   = size % BY;
    a     = ptr;
    left  = beats;
    idx   = 0;
    while (left > 0) begin
      room = (4096 - int'(a % 4096)) / BY;
      len  = MB;
      if (left < len) len = left;
      if (room < len) len = room;
      aw_q.push_back('{addr: a, len: 8'(len - 1)});
      for (int k = 0; k < int'(len); k++) begin
        w.data = pat(idx, salt);
        w.strb = (idx == beats - 1 && rem != 0) ? strb_of(rem) : '1;
        w.last = (k == int'(len) - 1);
        w_q.push_back(w);
        idx++;
      end
      a    = a + len * BY;
      left = left - len;
    end
  endtask

  // Source RAM with RDD cycles of read latency.
  logic [DW-1:0] rd_pipe [RDD];
  always @(posedge clk) begin
    rd_pipe[0] <= o_rden ? pat(int'(o_rdaddr), salt) : '0;
    for (int i = 1; i < RDD; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_rddata = rd_pipe[RDD-1];

  // Slave drive: readies and B responses, changed just after each edge.
  always @(posedge clk) begin
    #1;
    m_axi_awready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n && !b_hold && b_q.size() != 0) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = b_q[0];
    end else begin
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
    end
  end

  // Monitor: handshake scoreboard, payload stability, outstanding limit.
  logic          pv_aw = 1'b0, pv_w = 1'b0;
  logic [AW-1:0] pv_awaddr;
  logic [7:0]    pv_awlen;
  logic [DW-1:0] pv_wdata;
  logic [BY-1:0] pv_wstrb;
  logic          pv_wlast;
  always @(negedge clk) begin
    aw_t ea;
    w_t  ew;
    if (!rst_n) begin
      pv_aw = 1'b0;
      pv_w  = 1'b0;
    end else begin
      if (pv_aw) begin
        total++;
        if (!(m_axi_awvalid && m_axi_awaddr == pv_awaddr && m_axi_awlen == pv_awlen)) begin
          bad++;
          $display("FAIL aw_stable: valid=%b addr=%h len=%0d expected addr=%h len=%0d",
                   m_axi_awvalid, m_axi_awaddr, m_axi_awlen, pv_awaddr, pv_awlen);
        end
      end
      if (pv_w) begin
        total++;
        if (!(m_axi_wvalid && m_axi_wdata == pv_wdata && m_axi_wstrb == pv_wstrb && m_axi_wlast == pv_wlast)) begin
          bad++;
          $display("FAIL w_stable: valid=%b strb=%h last=%b expected strb=%h last=%b",
                   m_axi_wvalid, m_axi_wstrb, m_axi_wlast, pv_wstrb, pv_wlast);
        end
      end
      if (m_axi_awvalid) begin
        total++;
        if (aw_hs_cnt - b_hs_cnt >= MO) begin
          bad++;
          $display("FAIL aw_outstanding: outstanding=%0d limit=%0d", aw_hs_cnt - b_hs_cnt, MO);
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs_cnt++;
        total++;
        if (aw_q.size() == 0) begin
          bad++;
          $display("FAIL aw_unexpected: addr=%h len=%0d expected none", m_axi_awaddr, m_axi_awlen);
        end else begin
          ea = aw_q.pop_front();
          if (m_axi_awaddr !== ea.addr || m_axi_awlen !== ea.len) begin
            bad++;
            $display("FAIL aw_burst: addr=%h len=%0d expected addr=%h len=%0d",
                     m_axi_awaddr, m_axi_awlen, ea.addr, ea.len);
          end
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs_cnt++;
        total++;
        if (w_q.size() == 0) begin
          bad++;
          $display("FAIL w_unexpected: strb=%h last=%b expected none", m_axi_wstrb, m_axi_wlast);
        end else begin
          ew = w_q.pop_front();
          if (m_axi_wdata !== ew.data || m_axi_wstrb !== ew.strb || m_axi_wlast !== ew.last) begin
            bad++;
            $display("FAIL w_beat: data=%h strb=%h last=%b expected data=%h strb=%h last=%b",
                     m_axi_wdata, m_axi_wstrb, m_axi_wlast, ew.data, ew.strb, ew.last);
          end
        end
        if (m_axi_wlast) begin
          b_q.push_back((w_burst_cnt == err_burst) ? 2'b10 : 2'b00);
          w_burst_cnt++;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_hs_cnt++;
        if (b_q.size() != 0) void'(b_q.pop_front());
      end
      pv_aw     = m_axi_awvalid && !m_axi_awready;
      pv_awaddr = m_axi_awaddr;
      pv_awlen  = m_axi_awlen;
      pv_w      = m_axi_wvalid && !m_axi_wready;
      pv_wdata  = m_axi_wdata;
      pv_wstrb  = m_axi_wstrb;
      pv_wlast  = m_axi_wlast;
    end
  end

  task automatic start_xfer(input logic [AW-1:0] ptr, input int unsigned size);
    @(posedge clk);
    #2;
    salt        = $urandom;
    w_burst_cnt = 0;
    model(ptr, size);
    i_data_ptr   = ptr;
    i_size_bytes = size;
    i_start      = 1'b1;
    @(posedge clk);
    #2;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(o_done), 64'd1);
  endtask

  task automatic end_check(input string name, input logic exp_err);
    check({name, "_aw_left"}, 64'(aw_q.size()), 64'd0);
    check({name, "_w_left"},  64'(w_q.size()),  64'd0);
    check({name, "_b_left"},  64'(b_q.size()),  64'd0);
    check({name, "_err"},     64'(o_err),       64'(exp_err));
  endtask

  task automatic run(input string name, input logic [AW-1:0] ptr, input int unsigned size, input logic exp_err);
    start_xfer(ptr, size);
    wait_done(6000);
    end_check(name, exp_err);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    check({name, "_wvalid"},  64'(m_axi_wvalid),  64'd0);
    check({name, "_rden"},    64'(o_rden),        64'd0);
    check({name, "_rdaddr"},  64'(o_rdaddr),      64'd0);
    check({name, "_err"},     64'(o_err),         64'd0);
    check({name, "_done"},    64'(o_done),        64'd1);
    check({name, "_bready"},  64'(m_axi_bready),  64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int unsigned sz;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // single full-page burst
    run("t1", 64'h1000, 4096, 1'b0);
    // 4 KB split: one beat then three
    run("t2", 64'h0FC0, 256, 1'b0);
    // partial last beat of 36 bytes
    run("t3", 64'h2000, 100, 1'b0);

    // outstanding limit with responses withheld
    b_hold = 1'b1;
    base   = aw_hs_cnt;
    start_xfer(64'h3000, 3 * 4096);
    repeat (400) @(negedge clk);
    check("t4_aw_count", 64'(aw_hs_cnt - base), 64'd2);
    check("t4_awvalid_low", 64'(m_axi_awvalid), 64'd0);
    check("t4_not_done", 64'(o_done), 64'd0);
    b_hold = 1'b0;
    wait_done(6000);
    end_check("t4", 1'b0);

    // error response on the first of two bursts
    err_burst = 0;
    run("t5", 64'h8000, 8192, 1'b1);
    err_burst = -1;
    start_xfer(64'h9000, 64);
    @(negedge clk);
    check("t5_err_cleared", 64'(o_err), 64'd0);
    wait_done(6000);
    end_check("t5b", 1'b0);

    // randomized readiness, edge sizes and random transfers
    rnd_ready = 1'b1;
    start_xfer(64'h5000, 0);
    @(negedge clk);
    check("t6_zero_busy", 64'(o_done), 64'd0);
    @(negedge clk);
    check("t6_zero_idle", 64'(o_done), 64'd1);
    end_check("t6_zero", 1'b0);
    run("t6_one", 64'h0000_0001_0000_0FC0, 1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      sz = $urandom_range(1, 5000);
      run("t6_rand", 64'hABC0_0000_0000 | (64'($urandom_range(0, 255)) << 6), sz, 1'b0);
    end

    // reset pulsed in the middle of the data phase
    base = w_hs_cnt;
    start_xfer(64'h6040, 8192);
    n = 0;
    @(negedge clk);
    while (!((w_hs_cnt - base) >= 20 && m_axi_wvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_w", 64'(m_axi_wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    aw_q.delete();
    w_q.delete();
    b_q.delete();
    aw_hs_cnt = 0;
    b_hs_cnt  = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_post");
    run("t6_recover", 64'h7FC0, 1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
